// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   div_state_t   : divider control state (IDLE, RUN, DONE)
//   DIV_W_DEFAULT : default operand width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_W_DEFAULT = 16;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Ports:
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_sub.sv
// N-bit ripple-borrow subtractor, diff = a - b, built as a + ~b + 1 from a chain of
// full_adder cells.
// Ports:
//   a, b   : minuend and subtrahend
//   diff   : a - b modulo 2^N
//   borrow : high when b > a (inverse of the final carry)
module ripple_sub #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0]   carry;
    logic [N-1:0] b_inv;

    assign b_inv    = ~b;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b_inv[i]),
            .cin  (carry[i]),
            .sum  (diff[i]),
            .cout (carry[i+1])
        );
    end

    assign borrow = ~carry[N];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock (W cycles per result).
// Optional macro DIV_SIGNED_EN: two's complement operands, truncating division with the
// remainder taking the dividend's sign. Undefined: unsigned only.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid, in_ready    : operand handshake (in_ready high only when idle)
//   dividend, divisor     : W-bit operands
//   out_valid, out_ready  : result handshake (result held until accepted)
//   quotient, remainder   : W-bit registered results
module seq_divider
    import div_pkg::*;
#(
    parameter int W  = DIV_W_DEFAULT,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    div_state_t    state_q, state_d;
    logic [W:0]    rem_q, rem_d;        // partial remainder R
    logic [W-1:0]  quo_q, quo_d;        // quotient / dividend shift register Q
    logic [W-1:0]  dsr_q, dsr_d;        // latched divisor (magnitude in signed mode)
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quotient_q, quotient_d;
    logic [W-1:0]  remainder_q, remainder_d;

    logic [W:0]    sub_a, sub_b, sub_diff;
    logic          sub_borrow;
    logic [W:0]    rem_next;
    logic [W-1:0]  quo_next;
    logic [W-1:0]  load_dividend, load_divisor;
    logic [W-1:0]  res_quo, res_rem;

    // R never exceeds the divisor, so its top bit only carries the subtract width.
    logic          unused_rem_msb;
    assign unused_rem_msb = rem_q[W];

    // Shift the next dividend bit into R and trial-subtract the divisor.
    assign sub_a = {rem_q[W-1:0], quo_q[W-1]};
    assign sub_b = {1'b0, dsr_q};

    ripple_sub #(
        .N (W + 1)
    ) u_sub (
        .a      (sub_a),
        .b      (sub_b),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    // Restore on borrow, otherwise keep the difference and shift in a 1.
    assign rem_next = sub_borrow ? sub_a : sub_diff;
    assign quo_next = {quo_q[W-2:0], ~sub_borrow};

`ifdef DIV_SIGNED_EN
    logic sq_q, sq_d;   // negate quotient
    logic sr_q, sr_d;   // negate remainder

    assign load_dividend = dividend[W-1] ? (W'(0) - dividend) : dividend;
    assign load_divisor  = divisor[W-1]  ? (W'(0) - divisor)  : divisor;

    assign res_quo = sq_q ? (W'(0) - quo_next) : quo_next;
    assign res_rem = sr_q ? (W'(0) - rem_next[W-1:0]) : rem_next[W-1:0];

    always_comb begin
        sq_d = sq_q;
        sr_d = sr_q;
        if (state_q == IDLE && in_valid) begin
            // A zero divisor must keep the all-ones quotient, so never negate it.
            sq_d = (dividend[W-1] ^ divisor[W-1]) & (|divisor);
            sr_d = dividend[W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_q <= 1'b0;
            sr_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
            sr_q <= sr_d;
        end
    end
`else
    assign load_dividend = dividend;
    assign load_divisor  = divisor;
    assign res_quo       = quo_next;
    assign res_rem       = rem_next[W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_d   = '0;
                    quo_d   = load_dividend;
                    dsr_d   = load_divisor;
                    cnt_d   = CW'(W);
                    state_d = RUN;
                end
            end
            RUN: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Last iteration: publish the result from this step's next values.
                    state_d     = DONE;
                    quotient_d  = res_quo;
                    remainder_d = res_rem;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule
